// File: rtl/drawbridge_pkg.sv
// drawbridge_pkg: FSM state encoding and lane popcount shared by the drawbridge controller.
package drawbridge_pkg;
  typedef enum logic [2:0] {
    IDLE        = 3'b000,
    BOAT_C_CARS = 3'b001,
    BOAT_C      = 3'b010,
    RAISING     = 3'b011,
    UP          = 3'b100,
    LOWERING    = 3'b101
  } state_t;
  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/drawbridge_car_counter.sv
// drawbridge_car_counter: gated multi-lane occupancy counter with clamping and a sticky clamp error.
module drawbridge_car_counter
  import drawbridge_pkg::*;
#(
  parameter int N_LANES  = 2,
  parameter int MAX_CARS = 15,
  localparam int CNT_W   = $clog2(MAX_CARS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] car_in,
  input  logic [N_LANES-1:0] car_out,
  input  logic               barrier,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   count_next,
  output logic               has_car_c,
  output logic               err
);
  localparam int SW = CNT_W + $clog2(N_LANES) + 1;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_CARS);
  logic signed [SW-1:0] ins, outs, sum;
  logic under, over;
  assign ins        = barrier ? '0 : SW'(popcount(64'(car_in)));
  assign outs       = SW'(popcount(64'(car_out)));
  assign sum        = SW'(count) + ins - outs;
  assign under      = sum[SW-1];
  assign over       = !under && (sum > MAX_S);
  assign count_next = under ? '0 : over ? CNT_W'(MAX_CARS) : sum[CNT_W-1:0];
  assign has_car_c  = count != '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_next;
      err   <= err | under | over;
    end
endmodule

// File: rtl/drawbridge_multilane.sv
// drawbridge_multilane: multi-lane car admission and boat-driven bridge sequencing FSM.
// Optional drain watchdog enabled by DRAWBRIDGE_DRAIN_TIMEOUT_EN.
module drawbridge_multilane
  import drawbridge_pkg::*;
#(
  parameter int N_LANES   = 2,
  parameter int MAX_CARS  = 15,
  parameter int ALERT_CYC = 4,
  parameter int RAISE_CYC = 8,
  parameter int LOWER_CYC = 8,
`ifdef DRAWBRIDGE_DRAIN_TIMEOUT_EN
  parameter int DRAIN_TO  = 64,
`endif
  localparam int CNT_W    = $clog2(MAX_CARS + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [N_LANES-1:0] i_carIn,
  input  logic [N_LANES-1:0] i_carOut,
  input  logic               i_boatClose,
  input  logic               i_boatHere,
  output logic [CNT_W-1:0]   o_car_count,
  output logic               has_car_c,
  output logic               o_carBarrier,
  output logic               o_alert,
  output logic               o_bridge_s,
  output logic               o_err,
`ifdef DRAWBRIDGE_DRAIN_TIMEOUT_EN
  output logic               o_drain_timeout,
`endif
  output logic [2:0]         machine_state
);
  localparam int TMAX = ALERT_CYC > RAISE_CYC ? (ALERT_CYC > LOWER_CYC ? ALERT_CYC : LOWER_CYC)
                                              : (RAISE_CYC > LOWER_CYC ? RAISE_CYC : LOWER_CYC);
  localparam int TW = $clog2(TMAX + 1);
  state_t state, nxt;
  logic [TW-1:0] timer, timer_n;
  logic [CNT_W-1:0] count_next;
  logic gone;
  drawbridge_car_counter #(.N_LANES(N_LANES), .MAX_CARS(MAX_CARS)) u_cnt (
    .clk(i_clk), .rst(i_reset), .car_in(i_carIn), .car_out(i_carOut),
    .barrier(o_carBarrier), .count(o_car_count), .count_next(count_next),
    .has_car_c(has_car_c), .err(o_err)
  );
  assign gone = !i_boatClose && !i_boatHere;
  assign machine_state = state;
  always_comb begin
    nxt     = state;
    timer_n = timer;
    case (state)
      IDLE:
        if (i_boatClose) begin
          nxt     = count_next != '0 ? BOAT_C_CARS : BOAT_C;
          timer_n = TW'(ALERT_CYC - 1);
        end
      BOAT_C_CARS:
        if (count_next == '0) begin
          nxt     = BOAT_C;
          timer_n = TW'(ALERT_CYC - 1);
        end else if (!i_boatClose) nxt = IDLE;
      BOAT_C:
        if (timer == '0) begin
          nxt     = RAISING;
          timer_n = TW'(RAISE_CYC - 1);
        end else if (gone) nxt = IDLE;
        else timer_n = timer - 1'b1;
      RAISING:
        if (timer == '0) nxt = UP;
        else timer_n = timer - 1'b1;
      UP:
        if (gone) begin
          nxt     = LOWERING;
          timer_n = TW'(LOWER_CYC - 1);
        end
      LOWERING:
        if (timer == '0) nxt = IDLE;
        else timer_n = timer - 1'b1;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they line up with machine_state.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state        <= IDLE;
      timer        <= '0;
      o_carBarrier <= 1'b0;
      o_alert      <= 1'b0;
      o_bridge_s   <= 1'b0;
    end else begin
      state        <= nxt;
      timer        <= timer_n;
      o_carBarrier <= (nxt != IDLE) || (count_next == CNT_W'(MAX_CARS));
      o_alert      <= nxt != IDLE;
      o_bridge_s   <= nxt inside {RAISING, UP, LOWERING};
    end
`ifdef DRAWBRIDGE_DRAIN_TIMEOUT_EN
  localparam int DW = $clog2(DRAIN_TO + 1);
  logic [DW-1:0] drain_cnt;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      drain_cnt       <= '0;
      o_drain_timeout <= 1'b0;
    end else if (state != BOAT_C_CARS) drain_cnt <= '0;
    else if (drain_cnt == DW'(DRAIN_TO - 1)) o_drain_timeout <= 1'b1;
    else drain_cnt <= drain_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_drawbridge_multilane.sv
// tb_drawbridge_multilane: table-driven scoreboard bench for drawbridge_multilane (N_LANES=2, MAX_CARS=3).
module tb_drawbridge_multilane;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] car_in, car_out;
  logic       boat_close, boat_here;
  logic [1:0] car_count;
  logic       has_car, barrier, alert, bridge_s, err;
  logic [2:0] st;
  logic [9:0] obs;
`ifdef DRAWBRIDGE_DRAIN_TIMEOUT_EN
  logic       drain_to;
`endif
  typedef struct {
    string      name;
    logic [1:0] ci, co;
    logic       bc, bh;
    logic [9:0] exp;
  } vec_t;
  vec_t vecs[$];
  vec_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  drawbridge_multilane #(
    .N_LANES(2), .MAX_CARS(3), .ALERT_CYC(4), .RAISE_CYC(8), .LOWER_CYC(8)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_carIn(car_in), .i_carOut(car_out),
    .i_boatClose(boat_close), .i_boatHere(boat_here),
    .o_car_count(car_count), .has_car_c(has_car), .o_carBarrier(barrier),
    .o_alert(alert), .o_bridge_s(bridge_s), .o_err(err),
`ifdef DRAWBRIDGE_DRAIN_TIMEOUT_EN
    .o_drain_timeout(drain_to),
`endif
    .machine_state(st)
  );
  assign obs = {car_count, has_car, barrier, alert, bridge_s, err, st};
  function automatic logic [9:0] mk(int cnt, bit bar, bit al, bit br, bit er, int s);
    return {2'(cnt), cnt != 0, bar, al, br, er, 3'(s)};
  endfunction
  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cnt/has/bar/al/br/err/st=%b expected %b", name, act, exp);
    end
  endtask
  task automatic add(input string name, input logic [1:0] ci, input logic [1:0] co,
                     input bit bc, input bit bh, input int cnt, input bit bar,
                     input bit al, input bit br, input bit er, input int s);
    vec_t v;
    v.name = name; v.ci = ci; v.co = co; v.bc = bc; v.bh = bh;
    v.exp = mk(cnt, bar, al, br, er, s);
    vecs.push_back(v);
  endtask
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    car_in = v.ci; car_out = v.co; boat_close = v.bc; boat_here = v.bh;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(e.name, obs, e.exp);
  endtask
  initial begin
    vec_t h;
    rst = 1'b1; car_in = '0; car_out = '0; boat_close = 1'b0; boat_here = 1'b0;
    #2 check("reset", obs, mk(0, 0, 0, 0, 0, 0));
    @(negedge clk) rst = 1'b0;
    add("t1_in11",    2'b11, 2'b00, 0, 0, 2, 0, 0, 0, 0, 0);
    add("t1_in01",    2'b01, 2'b00, 0, 0, 3, 1, 0, 0, 0, 0);
    add("t1_gated",   2'b11, 2'b00, 0, 0, 3, 1, 0, 0, 0, 0);
    add("t1_out",     2'b00, 2'b01, 0, 0, 2, 0, 0, 0, 0, 0);
    add("t2_net",     2'b01, 2'b10, 0, 0, 2, 0, 0, 0, 0, 0);
    add("t2_drain",   2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
    add("t2_under",   2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 1, 0);
    add("t3_fill",    2'b11, 2'b00, 0, 0, 2, 0, 0, 0, 1, 0);
    add("t3_close",   2'b00, 2'b00, 1, 0, 2, 1, 1, 0, 1, 1);
    add("t3_exit",    2'b00, 2'b11, 1, 0, 0, 1, 1, 0, 1, 2);
    for (int i = 0; i < 3; i++) add("t3_alert", 2'b00, 2'b00, 1, 0, 0, 1, 1, 0, 1, 2);
    add("t3_raise",   2'b00, 2'b00, 1, 0, 0, 1, 1, 1, 1, 3);
    for (int i = 0; i < 7; i++) add("t3_raising", 2'b00, 2'b00, 1, 0, 0, 1, 1, 1, 1, 3);
    add("t3_up",      2'b00, 2'b00, 1, 0, 0, 1, 1, 1, 1, 4);
    add("t4_here",    2'b00, 2'b00, 0, 1, 0, 1, 1, 1, 1, 4);
    add("t4_lower",   2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 1, 5);
    for (int i = 0; i < 7; i++) add("t4_lowering", 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 1, 5);
    add("t4_idle",    2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    add("t5_alert3",  2'b00, 2'b00, 1, 0, 0, 1, 1, 0, 1, 2);
    add("t5_alert2",  2'b00, 2'b00, 1, 0, 0, 1, 1, 0, 1, 2);
    add("t5_abort",   2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    add("t5_stay",    2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    add("cars_in",    2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 1, 0);
    add("cars_close", 2'b00, 2'b00, 1, 0, 1, 1, 1, 0, 1, 1);
    add("cars_abort", 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 1, 0);
    add("cars_out",   2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0);
    foreach (vecs[i]) step(vecs[i]);
    h.ci = '0; h.co = '0; h.bh = 1'b0; h.bc = 1'b1;
    h.name = "t6_alert"; h.exp = mk(0, 1, 1, 0, 1, 2);
    for (int i = 0; i < 4; i++) step(h);
    h.name = "t6_raise"; h.exp = mk(0, 1, 1, 1, 1, 3);
    for (int i = 0; i < 3; i++) step(h);
    #2 rst = 1'b1;
    #1 check("t6_async_reset", obs, mk(0, 0, 0, 0, 0, 0));
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/drawbridge_multilane.md
Name: drawbridge_multilane

Overview:
Parametrised successor to the single-lane drawbridge controller. Tracks car occupancy across N_LANES entry/exit sensor pairs and enforces a capacity limit. Sequences boat-driven bridge raising through timed alert, raise, up and lower phases. Sits between the lane and boat sensors and the barrier, alert and bridge actuators; state is exported for monitoring.

Parameters:
N_LANES, 2, number of lanes; each lane has one carIn and one carOut pulse per cycle
MAX_CARS, 15, occupancy capacity; CNT_W = $clog2(MAX_CARS+1) is a localparam
ALERT_CYC, 4, cycles of alert with an empty bridge before raising starts
RAISE_CYC, 8, cycles spent in RAISING
LOWER_CYC, 8, cycles spent in LOWERING

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_carIn  in  N_LANES  per-lane car-entry pulse
i_carOut  in  N_LANES  per-lane car-exit pulse
i_boatClose  in  1  boat approaching
i_boatHere  in  1  boat under or through the bridge
o_car_count  out  CNT_W  registered occupancy
has_car_c  out  1  o_car_count != 0 (combinational from the register)
o_carBarrier  out  1  1 = entry barrier closed
o_alert  out  1  warning lights
o_bridge_s  out  1  1 = bridge not down (RAISING/UP/LOWERING)
o_err  out  1  sticky: occupancy clamp occurred
machine_state  out  3  current FSM state

Behaviour:
- Reset (async): state IDLE, count 0, timer 0, o_err 0, all outputs 0.
- States (pkg): IDLE 000, BOAT_C_CARS 001, BOAT_C 010, RAISING 011, UP 100, LOWERING 101. 110 and 111 recover to IDLE.
- Admission: ins = popcount(i_carIn) when o_carBarrier==0 at the sampling edge, else 0. outs = popcount(i_carOut), always counted.
- Count update: next = count + ins - outs, computed at CNT_W+$clog2(N_LANES)+1 signed width and clamped to [0, MAX_CARS]. Any clamp sets o_err. Simultaneous in/out nets out with no error.
- Transitions, evaluated on the registered state and post-update count:
  - IDLE: boatClose & count!=0 -> BOAT_C_CARS. boatClose & count==0 -> BOAT_C, timer=ALERT_CYC-1.
  - BOAT_C_CARS: next count==0 -> BOAT_C (timer loaded). !boatClose -> IDLE.
  - BOAT_C: timer==0 -> RAISING, timer=RAISE_CYC-1. !boatClose & !boatHere -> IDLE. Otherwise decrement.
  - RAISING: timer==0 -> UP, else decrement. Not abortable.
  - UP: !boatClose & !boatHere -> LOWERING, timer=LOWER_CYC-1.
  - LOWERING: timer==0 -> IDLE. Runs to completion; a boat arriving mid-lower is handled from IDLE.
- Outputs (registered, decoded from next state):
  - o_carBarrier = (state!=IDLE) | (count==MAX_CARS).
  - o_alert = state!=IDLE.
  - o_bridge_s = state in {RAISING, UP, LOWERING}.
- Latency: a boatClose pulse is visible on machine_state/o_alert one edge later. ALERT_CYC+RAISE_CYC cycles elapse from entering BOAT_C to UP.

Optional Feature:
DRAWBRIDGE_DRAIN_TIMEOUT_EN.
- Defined: adds parameter DRAIN_TO (default 64) and output o_drain_timeout (1 bit, sticky until reset). The flag sets when BOAT_C_CARS persists for DRAIN_TO consecutive cycles; the FSM is unaffected.
- Undefined: neither the port nor the counter exists.

Decomposition:
- drawbridge_pkg: state localparams/typedef and a popcount function.
- Sub-module drawbridge_car_counter: handles admission gating, popcount, clamp and o_err. It takes the N_LANES and MAX_CARS parameters and the barrier as input, and outputs count and has_car_c.
- The FSM and timer stay in the top level.

Test Plan (N_LANES=2, MAX_CARS=3, ALERT=4, RAISE=8, LOWER=8):
1. i_carIn=2'b11 for one cycle, then 2'b01 -> count 2, then 3. Barrier goes to 1 the cycle count reaches 3, and further carIn is ignored.
2. count=2, i_carIn=2'b01 and i_carOut=2'b10 in the same cycle -> count stays 2, o_err 0. From count=0, i_carOut=2'b11 -> count 0, o_err=1.
3. count=2, boatClose=1 -> 001, barrier 1, alert 1. Two exits -> 010. After 4 cycles -> 011; after 8 more -> 100 with o_bridge_s=1.
4. In UP, drop boatClose while boatHere=1 -> stays 100. Drop boatHere -> 101. After 8 cycles -> 000 with barrier, alert and bridge_s all 0.
5. In BOAT_C, drop boatClose at timer=2 -> 000 next edge, no raise.
6. Assert i_reset asynchronously mid-RAISING -> all outputs 0 and state 000 before the next edge. Count 0.
